// File: rtl/char_glyph_streamer.sv
// char_glyph_streamer: accepts one ASCII character per handshake, fetches its
// glyph from a synchronous ROM and streams the glyph rows plus blank gap rows
// to the display driver under row_valid/row_ready flow control.
module char_glyph_streamer #(
    parameter int unsigned ROW_W      = 8,
    parameter int unsigned ROWS       = 5,
    parameter int unsigned GAP_ROWS   = 1,
    parameter int unsigned ADDR_W     = 7,
    parameter logic [7:0]  FIRST_CHAR = 8'h20,
    parameter logic [7:0]  LAST_CHAR  = 8'h7f,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              char_in,
    input  logic                    char_valid,
    output logic                    char_ready,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [ROWS*ROW_W-1:0]   rom_data,
    output logic [ROW_W-1:0]        row_data,
    output logic [IDX_W-1:0]        row_idx,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic                    row_last,
    output logic                    bad_char
);

    localparam int unsigned GLYPH_W = ROWS * ROW_W;
    localparam int unsigned BEATS   = ROWS + GAP_ROWS;
    localparam int unsigned LAT_W   = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_GLYPH_IDX = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] FIRST_GAP_IDX  = IDX_W'(ROWS);
    localparam logic [IDX_W-1:0] LAST_BEAT_IDX  = IDX_W'(BEATS - 1);
    localparam logic [LAT_W-1:0] LAT_DONE       = LAT_W'(ROM_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_GAP
    } state_t;

    state_t               state, state_nxt;
    logic [LAT_W-1:0]     lat_cnt, lat_cnt_nxt;
    logic [GLYPH_W-1:0]   glyph, glyph_nxt;
    logic [ADDR_W-1:0]    rom_addr_nxt;
    logic [ROW_W-1:0]     row_data_nxt;
    logic [IDX_W-1:0]     row_idx_nxt;
    logic                 row_valid_nxt;
    logic                 row_last_nxt;
    logic                 bad_char_nxt;
    logic                 char_ready_nxt;
    logic                 char_in_range;

    // Row idx of a glyph word; row 0 sits in the MSB slice.
    function automatic logic [ROW_W-1:0] glyph_row(input logic [GLYPH_W-1:0] g,
                                                   input logic [IDX_W-1:0]   idx);
        logic [GLYPH_W-1:0] shifted;
        shifted = g << (idx * ROW_W);
        return shifted[GLYPH_W-1 -: ROW_W];
    endfunction

    assign char_in_range = (char_in >= FIRST_CHAR) && (char_in <= LAST_CHAR);

    // Next-state and next-output logic for the fetch/stream sequencer.
    always_comb begin
        state_nxt      = state;
        lat_cnt_nxt    = lat_cnt;
        glyph_nxt      = glyph;
        rom_addr_nxt   = rom_addr;
        row_data_nxt   = row_data;
        row_idx_nxt    = row_idx;
        row_valid_nxt  = row_valid;
        bad_char_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                row_valid_nxt = 1'b0;
                if (char_valid && char_ready) begin
                    if (char_in_range) begin
                        rom_addr_nxt = ADDR_W'(char_in - FIRST_CHAR);
                    end else begin
                        rom_addr_nxt = '0;
                        bad_char_nxt = 1'b1;
                    end
                    lat_cnt_nxt = '0;
                    state_nxt   = S_FETCH;
                end
            end

            S_FETCH: begin
                if (lat_cnt == LAT_DONE) begin
                    glyph_nxt     = rom_data;
                    row_idx_nxt   = '0;
                    row_data_nxt  = glyph_row(rom_data, '0);
                    row_valid_nxt = 1'b1;
                    state_nxt     = S_STREAM;
                end else begin
                    lat_cnt_nxt = lat_cnt + LAT_W'(1);
                end
            end

            S_STREAM: begin
                if (row_ready) begin
                    if (row_idx == LAST_GLYPH_IDX) begin
                        if (GAP_ROWS > 0) begin
                            row_idx_nxt  = FIRST_GAP_IDX;
                            row_data_nxt = '0;
                            state_nxt    = S_GAP;
                        end else begin
                            row_idx_nxt   = '0;
                            row_data_nxt  = '0;
                            row_valid_nxt = 1'b0;
                            state_nxt     = S_IDLE;
                        end
                    end else begin
                        row_idx_nxt  = row_idx + IDX_W'(1);
                        row_data_nxt = glyph_row(glyph, row_idx + IDX_W'(1));
                    end
                end
            end

            S_GAP: begin
                row_data_nxt = '0;
                if (row_ready) begin
                    if (row_idx == LAST_BEAT_IDX) begin
                        row_idx_nxt   = '0;
                        row_valid_nxt = 1'b0;
                        state_nxt     = S_IDLE;
                    end else begin
                        row_idx_nxt = row_idx + IDX_W'(1);
                    end
                end
            end

            default: begin
                row_valid_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
        endcase

        char_ready_nxt = (state_nxt == S_IDLE);
        row_last_nxt   = row_valid_nxt && (row_idx_nxt == LAST_BEAT_IDX);
    end

    // State and registered outputs; synchronous reset discards any in-flight glyph.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            glyph      <= '0;
            rom_addr   <= '0;
            row_data   <= '0;
            row_idx    <= '0;
            row_valid  <= 1'b0;
            row_last   <= 1'b0;
            bad_char   <= 1'b0;
            char_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            glyph      <= glyph_nxt;
            rom_addr   <= rom_addr_nxt;
            row_data   <= row_data_nxt;
            row_idx    <= row_idx_nxt;
            row_valid  <= row_valid_nxt;
            row_last   <= row_last_nxt;
            bad_char   <= bad_char_nxt;
            char_ready <= char_ready_nxt;
        end
    end

endmodule
